// File: rtl/tot_raw_generator_if.sv
// Purpose: bundles the code-input, sweep-control and raw-word output signals
//          of tot_raw_generator.
// Ports:   none; signals only.
//   master : the generator (drives inReady, TOTRaw, TOTCntA/B, outCode,
//            outValid, busy, sweepDone)
//   slave  : the stimulus/consumer side (drives everything else)
interface tot_raw_generator_if;
    logic [8:0]  inCode;
    logic        inValid;
    logic        inReady;
    logic        sweepStart;
    logic [8:0]  sweepFirst;
    logic [8:0]  sweepLast;
    logic [8:0]  sweepStep;
    logic [5:0]  offset;
    logic [31:0] bubbleMask;
    logic [31:0] TOTRaw;
    logic [2:0]  TOTCntA;
    logic [2:0]  TOTCntB;
    logic [8:0]  outCode;
    logic        outValid;
    logic        outReady;
    logic        busy;
    logic        sweepDone;

    modport master (
        input  inCode, inValid, sweepStart, sweepFirst, sweepLast, sweepStep,
               offset, bubbleMask, outReady,
        output inReady, TOTRaw, TOTCntA, TOTCntB, outCode, outValid, busy,
               sweepDone
    );

    modport slave (
        output inCode, inValid, sweepStart, sweepFirst, sweepLast, sweepStep,
               offset, bubbleMask, outReady,
        input  inReady, TOTRaw, TOTCntA, TOTCntB, outCode, outValid, busy,
               sweepDone
    );
endinterface

// File: rtl/tot_raw_generator.sv
// Purpose: inverse TOT encoder. Turns a 9-bit phase code {coarse, fine} into
//          the 32-bit delay-line snapshot plus the two ripple-counter values
//          the encoder consumes, either one code at a time or as an
//          autonomous sweep over a code range.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : tot_raw_generator_if.master (code input handshake, sweep control,
//            offset / bubble mask, raw-word output handshake, status)
module tot_raw_generator #(
    parameter int unsigned HOLD_CYCLES  = 0,
    parameter bit          APPLY_OFFSET = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    tot_raw_generator_if.master  bus
);

    localparam int unsigned CODE_W = 9;
    localparam int unsigned RAW_W  = 32;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SINGLE,
        SWEEP_EMIT,
        SWEEP_HOLD,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [RAW_W-1:0]    raw_q, raw_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
    logic [CODE_W-1:0]   out_code_q, out_code_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                sweep_done_q, sweep_done_d;
    logic [CODE_W-1:0]   cur_q, cur_d;
    logic [CODE_W-1:0]   last_q, last_d;
    logic [CODE_W-1:0]   step_q, step_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                load_en;
    logic [CODE_W-1:0]   load_code;
    logic                in_ready_c;
    logic                xfer;
    logic [CODE_W:0]     nxt;
    logic                sweep_end;

    logic [CODE_W-1:0]   eff;
    logic [RAW_W-1:0]    ones;
    logic [RAW_W-1:0]    fill;

    assign xfer = out_valid_q & bus.outReady;

    // 10-bit add so codes past 511 terminate the sweep instead of wrapping;
    // any nxt >= 512 is necessarily above the 9-bit last bound.
    assign nxt       = {1'b0, cur_q} + {1'b0, step_q};
    assign sweep_end = (nxt > {1'b0, last_q});

    // Next-state / control
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        busy_d       = busy_q;
        sweep_done_d = 1'b0;
        cur_d        = cur_q;
        last_d       = last_q;
        step_d       = step_q;
        hold_d       = hold_q;
        load_en      = 1'b0;
        load_code    = cur_q;
        in_ready_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sweepStart) begin
                    cur_d       = bus.sweepFirst;
                    last_d      = bus.sweepLast;
                    step_d      = (bus.sweepStep == '0) ? CODE_W'(1) : bus.sweepStep;
                    busy_d      = 1'b1;
                    load_en     = 1'b1;
                    load_code   = bus.sweepFirst;
                    out_valid_d = 1'b1;
                    state_d     = SWEEP_EMIT;
                end else begin
                    in_ready_c = ~out_valid_q | xfer;
                    if (bus.inValid && in_ready_c) begin
                        load_en     = 1'b1;
                        load_code   = bus.inCode;
                        out_valid_d = 1'b1;
                        state_d     = SINGLE;
                    end
                end
            end
            SINGLE: begin
                // Re-accept in the transfer cycle keeps one word per clock.
                in_ready_c = xfer;
                if (xfer) begin
                    if (bus.inValid) begin
                        load_en   = 1'b1;
                        load_code = bus.inCode;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            SWEEP_EMIT: begin
                if (xfer) begin
                    if (sweep_end) begin
                        out_valid_d  = 1'b0;
                        busy_d       = 1'b0;
                        sweep_done_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        cur_d = nxt[CODE_W-1:0];
                        if (HOLD_CYCLES == 0) begin
                            load_en   = 1'b1;
                            load_code = nxt[CODE_W-1:0];
                        end else begin
                            out_valid_d = 1'b0;
                            hold_d      = '0;
                            state_d     = SWEEP_HOLD;
                        end
                    end
                end
            end
            SWEEP_HOLD: begin
                // Load on the final idle cycle so the word is valid right after.
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    load_en     = 1'b1;
                    load_code   = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = SWEEP_EMIT;
                end else begin
                    hold_d = HOLD_W'(hold_q + 1'b1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Code-to-raw mapping; offset and bubble mask are taken in the load cycle
    always_comb begin
        eff = load_code;
        if (APPLY_OFFSET) begin
            eff = CODE_W'(load_code + CODE_W'(bus.offset));
        end
        ones = '1;
        fill = ones >> eff[4:0];

        raw_d      = raw_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        out_code_d = out_code_q;
        if (load_en) begin
            // fine<32: ones from MSB; fine>=32: zeros from MSB over ones.
            raw_d      = (eff[5] ? fill : ~fill) ^ bus.bubbleMask;
            cnt_a_d    = eff[8:6];
            cnt_b_d    = eff[5] ? eff[8:6] : CNT_W'(eff[8:6] - CNT_W'(1));
            out_code_d = load_code;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            raw_q        <= '0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            out_code_q   <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            cur_q        <= '0;
            last_q       <= '0;
            step_q       <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            raw_q        <= raw_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
            out_code_q   <= out_code_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
        end
    end

    assign bus.inReady   = in_ready_c & ~reset;
    assign bus.TOTRaw    = raw_q;
    assign bus.TOTCntA   = cnt_a_q;
    assign bus.TOTCntB   = cnt_b_q;
    assign bus.outCode   = out_code_q;
    assign bus.outValid  = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sweepDone = sweep_done_q;

endmodule

// File: tb/tb_tot_raw_generator.sv
// Purpose: directed self-checking bench for tot_raw_generator
//          (HOLD_CYCLES=2, APPLY_OFFSET=1). Inputs change on the falling
//          edge; outputs are sampled on the falling edge.
module tb_tot_raw_generator;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    tot_raw_generator_if bus();

    tot_raw_generator #(
        .HOLD_CYCLES (2),
        .APPLY_OFFSET(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic idle_inputs();
        bus.inValid    = 1'b0;
        bus.inCode     = '0;
        bus.sweepStart = 1'b0;
        bus.sweepFirst = '0;
        bus.sweepLast  = '0;
        bus.sweepStep  = '0;
        bus.offset     = '0;
        bus.bubbleMask = '0;
        bus.outReady   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.inValid = 1'b1;
        bus.inCode  = 9'd194;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode, bus.outValid,
             bus.busy, bus.sweepDone} !== 52'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got raw=%h a=%0d b=%0d code=%0d v=%b busy=%b done=%b, want all 0",
                     bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode, bus.outValid, bus.busy, bus.sweepDone);
        end
        n_cmp++;
        if (bus.inReady !== 1'b0) begin
            n_err++;
            $display("FAIL reset_inready: got %b want 0", bus.inReady);
        end
        reset = 1'b0;
        bus.inValid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [8:0]  codes [3] = '{9'd194, 9'd360, 9'd0};
        logic [31:0] raws  [3] = '{32'hC000_0000, 32'h00FF_FFFF, 32'h0000_0000};
        logic [2:0]  ea    [3] = '{3'd3, 3'd5, 3'd0};
        logic [2:0]  eb    [3] = '{3'd2, 3'd5, 3'd7};
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.inCode  = codes[i];
            bus.inValid = 1'b1;
            #1;
            n_cmp++;
            if (bus.inReady !== 1'b1) begin
                n_err++;
                $display("FAIL single[%0d]_inready: got %b want 1", i, bus.inReady);
            end
            @(negedge clk);
            n_cmp++;
            if ({bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode} !==
                {1'b1, raws[i], ea[i], eb[i], codes[i]}) begin
                n_err++;
                $display("FAIL single[%0d]_word: got v=%b raw=%h a=%0d b=%0d code=%0d want v=1 raw=%h a=%0d b=%0d code=%0d",
                         i, bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode,
                         raws[i], ea[i], eb[i], codes[i]);
            end
        end
        bus.inValid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.outValid, bus.inReady} !== 2'b01) begin
            n_err++;
            $display("FAIL single_drain: got v=%b rdy=%b want v=0 rdy=1", bus.outValid, bus.inReady);
        end
    endtask

    task automatic test_offset_mask();
        logic [8:0]  codes [3] = '{9'd511, 9'd194, 9'd30};
        logic [5:0]  offs  [3] = '{6'd1, 6'd0, 6'd5};
        logic [31:0] masks [3] = '{32'h0, 32'h0000_0001, 32'h0};
        logic [31:0] raws  [3] = '{32'h0000_0000, 32'hC000_0001, 32'h1FFF_FFFF};
        logic [2:0]  ea    [3] = '{3'd0, 3'd3, 3'd0};
        logic [2:0]  eb    [3] = '{3'd7, 3'd2, 3'd0};
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.inCode     = codes[i];
            bus.offset     = offs[i];
            bus.bubbleMask = masks[i];
            bus.inValid    = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode} !==
                {1'b1, raws[i], ea[i], eb[i], codes[i]}) begin
                n_err++;
                $display("FAIL offset[%0d]_word: got v=%b raw=%h a=%0d b=%0d code=%0d want v=1 raw=%h a=%0d b=%0d code=%0d",
                         i, bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode,
                         raws[i], ea[i], eb[i], codes[i]);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic       ev [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0] ec [9] = '{9'd0, 9'd0, 9'd0, 9'd4, 9'd0, 9'd0, 9'd8, 9'd0, 9'd0};
        logic       eb [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ed [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        idle_inputs();
        bus.sweepFirst = 9'd0;
        bus.sweepLast  = 9'd10;
        bus.sweepStep  = 9'd4;
        bus.sweepStart = 1'b1;
        bus.inValid    = 1'b1;
        bus.inCode     = 9'd77;
        #1;
        n_cmp++;
        if (bus.inReady !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_start_inready: got %b want 0", bus.inReady);
        end
        @(negedge clk);
        bus.sweepStart = 1'b0;
        bus.inValid    = 1'b0;
        // Parameters were captured at start; these must be ignored.
        bus.sweepFirst = 9'd300;
        bus.sweepLast  = 9'd400;
        bus.sweepStep  = 9'd1;
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if ({bus.outValid, bus.busy, bus.sweepDone} !== {ev[i], eb[i], ed[i]}) begin
                n_err++;
                $display("FAIL sweep_cyc[%0d]: got v=%b busy=%b done=%b want v=%b busy=%b done=%b",
                         i, bus.outValid, bus.busy, bus.sweepDone, ev[i], eb[i], ed[i]);
            end
            if (ev[i]) begin
                n_cmp++;
                if (bus.outCode !== ec[i]) begin
                    n_err++;
                    $display("FAIL sweep_code[%0d]: got %0d want %0d", i, bus.outCode, ec[i]);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if ({bus.TOTRaw, bus.TOTCntA, bus.TOTCntB} !== {32'hFF00_0000, 3'd0, 3'd7}) begin
                    n_err++;
                    $display("FAIL sweep_word8: got raw=%h a=%0d b=%0d want raw=ff000000 a=0 b=7",
                             bus.TOTRaw, bus.TOTCntA, bus.TOTCntB);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sweep_edges();
        logic       ev [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [8:0] ec [6] = '{9'd510, 9'd0, 9'd0, 9'd511, 9'd0, 9'd0};
        logic       eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       fv [3] = '{1'b1, 1'b0, 1'b0};
        logic       fb [3] = '{1'b1, 1'b0, 1'b0};
        logic       fd [3] = '{1'b0, 1'b1, 1'b0};
        // Step 0 acts as 1; last at the top of the code range stops at 512.
        idle_inputs();
        bus.sweepFirst = 9'd510;
        bus.sweepLast  = 9'd511;
        bus.sweepStep  = 9'd0;
        bus.sweepStart = 1'b1;
        @(negedge clk);
        bus.sweepStart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({bus.outValid, bus.busy, bus.sweepDone} !== {ev[i], eb[i], ed[i]}) begin
                n_err++;
                $display("FAIL top_cyc[%0d]: got v=%b busy=%b done=%b want v=%b busy=%b done=%b",
                         i, bus.outValid, bus.busy, bus.sweepDone, ev[i], eb[i], ed[i]);
            end
            if (ev[i]) begin
                n_cmp++;
                if ({bus.outCode, bus.TOTCntA, bus.TOTCntB} !== {ec[i], 3'd7, 3'd7}) begin
                    n_err++;
                    $display("FAIL top_code[%0d]: got code=%0d a=%0d b=%0d want code=%0d a=7 b=7",
                             i, bus.outCode, bus.TOTCntA, bus.TOTCntB, ec[i]);
                end
            end
            @(negedge clk);
        end
        // First above last: exactly one word.
        bus.sweepFirst = 9'd20;
        bus.sweepLast  = 9'd5;
        bus.sweepStep  = 9'd3;
        bus.sweepStart = 1'b1;
        @(negedge clk);
        bus.sweepStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({bus.outValid, bus.busy, bus.sweepDone} !== {fv[i], fb[i], fd[i]}) begin
                n_err++;
                $display("FAIL inv_cyc[%0d]: got v=%b busy=%b done=%b want v=%b busy=%b done=%b",
                         i, bus.outValid, bus.busy, bus.sweepDone, fv[i], fb[i], fd[i]);
            end
            if (fv[i]) begin
                n_cmp++;
                if (bus.outCode !== 9'd20) begin
                    n_err++;
                    $display("FAIL inv_code: got %0d want 20", bus.outCode);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [8:0] seen [$];
        int         done_cnt = 0;
        idle_inputs();
        bus.sweepFirst = 9'd100;
        bus.sweepLast  = 9'd120;
        bus.sweepStep  = 9'd10;
        bus.sweepStart = 1'b1;
        bus.outReady   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.sweepStart = 1'b1;
            bus.sweepFirst = 9'd300;
            bus.inValid    = 1'b1;
            bus.inCode     = 9'd5;
            bus.bubbleMask = 32'hFFFF_0000;
            #1;
            n_cmp++;
            if (bus.inReady !== 1'b0) begin
                n_err++;
                $display("FAIL stall[%0d]_inready: got %b want 0", i, bus.inReady);
            end
            n_cmp++;
            if ({bus.outValid, bus.busy, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode} !==
                {1'b1, 1'b1, 32'h0FFF_FFFF, 3'd1, 3'd1, 9'd100}) begin
                n_err++;
                $display("FAIL stall[%0d]_hold: got v=%b busy=%b raw=%h a=%0d b=%0d code=%0d want v=1 busy=1 raw=0fffffff a=1 b=1 code=100",
                         i, bus.outValid, bus.busy, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode);
            end
            @(negedge clk);
        end
        idle_inputs();
        for (int i = 0; i < 12; i++) begin
            if (bus.outValid === 1'b1) seen.push_back(bus.outCode);
            if (bus.sweepDone === 1'b1) done_cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (seen.size() != 3) begin
            n_err++;
            $display("FAIL bp_count: got %0d words want 3", seen.size());
        end else begin
            n_cmp++;
            if ({seen[0], seen[1], seen[2]} !== {9'd100, 9'd110, 9'd120}) begin
                n_err++;
                $display("FAIL bp_codes: got %0d,%0d,%0d want 100,110,120", seen[0], seen[1], seen[2]);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_done: got pulses=%0d busy=%b want pulses=1 busy=0", done_cnt, bus.busy);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad = 0;
        idle_inputs();
        bus.sweepFirst = 9'd66;
        bus.sweepLast  = 9'd200;
        bus.sweepStep  = 9'd5;
        bus.sweepStart = 1'b1;
        @(negedge clk);
        bus.sweepStart = 1'b0;
        n_cmp++;
        if ({bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB} !== {1'b1, 32'hC000_0000, 3'd1, 3'd0}) begin
            n_err++;
            $display("FAIL mid_first: got v=%b raw=%h a=%0d b=%0d want v=1 raw=c0000000 a=1 b=0",
                     bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB);
        end
        @(negedge clk);
        n_cmp++;
        if ({bus.outValid, bus.busy} !== 2'b01) begin
            n_err++;
            $display("FAIL mid_hold: got v=%b busy=%b want v=0 busy=1", bus.outValid, bus.busy);
        end
        reset = 1'b1;
        bus.inValid = 1'b1;
        bus.inCode  = 9'd194;
        @(negedge clk);
        n_cmp++;
        if ({bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode, bus.outValid,
             bus.busy, bus.sweepDone, bus.inReady} !== 53'h0) begin
            n_err++;
            $display("FAIL mid_reset: got raw=%h a=%0d b=%0d code=%0d v=%b busy=%b done=%b rdy=%b want all 0",
                     bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode, bus.outValid,
                     bus.busy, bus.sweepDone, bus.inReady);
        end
        reset = 1'b0;
        bus.inValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.outValid !== 1'b0 || bus.sweepDone !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got %0d active cycles want 0", bad);
        end
        bus.inCode  = 9'd194;
        bus.inValid = 1'b1;
        #1;
        n_cmp++;
        if (bus.inReady !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_inready: got %b want 1", bus.inReady);
        end
        @(negedge clk);
        bus.inValid = 1'b0;
        n_cmp++;
        if ({bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode} !==
            {1'b1, 32'hC000_0000, 3'd3, 3'd2, 9'd194}) begin
            n_err++;
            $display("FAIL post_reset_word: got v=%b raw=%h a=%0d b=%0d code=%0d want v=1 raw=c0000000 a=3 b=2 code=194",
                     bus.outValid, bus.TOTRaw, bus.TOTCntA, bus.TOTCntB, bus.outCode);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_offset_mask();
        test_sweep();
        test_sweep_edges();
        test_backpressure();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
